// File: rtl/traffic_phase_controller.sv
// Two-road intersection sequencer: NS/EW green, yellow and all-red clearance,
// with pedestrian request latching, green shortening and WALK during all-red.
//
// state  | meaning
// RED_NS | all-red clearance before NS green (WALK when granted)
// NS_G   | NS green, EW red
// NS_Y   | NS yellow, EW red
// RED_EW | all-red clearance before EW green (WALK when granted)
// EW_G   | EW green, NS red
// EW_Y   | EW yellow, NS red
module traffic_phase_controller #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned GREEN_SEC     = 35,
   parameter int unsigned YELLOW_SEC    = 5,
   parameter int unsigned ALL_RED_SEC   = 1,
   parameter int unsigned PED_SHORT_SEC = 10,
   parameter int unsigned WALK_SEC      = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        ped_req,
   output logic [2:0]  ns_light,
   output logic [2:0]  ew_light,
   output logic        ped_walk,
   output logic        ped_pending,
   output logic [2:0]  phase,
   output logic [31:0] ticks_remaining
);

   localparam logic [63:0] P_GREEN   = 64'(GREEN_SEC)     * 64'(TICKS_PER_SEC);
   localparam logic [63:0] P_YELLOW  = 64'(YELLOW_SEC)    * 64'(TICKS_PER_SEC);
   localparam logic [63:0] P_ALL_RED = 64'(ALL_RED_SEC)   * 64'(TICKS_PER_SEC);
   localparam logic [63:0] P_SHORT   = 64'(PED_SHORT_SEC) * 64'(TICKS_PER_SEC);
   localparam logic [63:0] P_WALK    = 64'(WALK_SEC)      * 64'(TICKS_PER_SEC);
   localparam logic [63:0] P_MAX     = 64'h0000_0000_FFFF_FFFF;

   // A zero product would wrap D to all-ones, so it is rejected as well.
   if (P_GREEN > P_MAX || P_YELLOW > P_MAX || P_ALL_RED > P_MAX ||
       P_SHORT > P_MAX || P_WALK > P_MAX ||
       P_GREEN == 64'd0 || P_YELLOW == 64'd0 || P_ALL_RED == 64'd0 ||
       P_SHORT == 64'd0 || P_WALK == 64'd0) begin : g_duration_range
      $error("traffic_phase_controller: phase duration does not fit in 32 bits");
   end

   localparam logic [31:0] D_GREEN   = 32'(P_GREEN   - 64'd1);
   localparam logic [31:0] D_YELLOW  = 32'(P_YELLOW  - 64'd1);
   localparam logic [31:0] D_ALL_RED = 32'(P_ALL_RED - 64'd1);
   localparam logic [31:0] D_SHORT   = 32'(P_SHORT   - 64'd1);
   localparam logic [31:0] D_WALK    = 32'(P_WALK    - 64'd1);

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   typedef enum logic [2:0] {
      RED_NS = 3'd0,
      NS_G   = 3'd1,
      NS_Y   = 3'd2,
      RED_EW = 3'd3,
      EW_G   = 3'd4,
      EW_Y   = 3'd5
   } phase_t;

   phase_t      state_q, state_nxt;
   logic [31:0] ticks_q, ticks_nxt;
   logic        walk_q, walk_nxt;
   logic        pend_q, pend_nxt;
   logic [2:0]  ns_q, ns_nxt;
   logic [2:0]  ew_q, ew_nxt;
   logic        req_eff;
   logic        is_green;
   logic        illegal;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RED_NS;
         ticks_q <= D_ALL_RED;
         walk_q  <= 1'b0;
         pend_q  <= 1'b0;
         ns_q    <= LAMP_R;
         ew_q    <= LAMP_R;
      end else begin
         state_q <= state_nxt;
         ticks_q <= ticks_nxt;
         walk_q  <= walk_nxt;
         pend_q  <= pend_nxt;
         ns_q    <= ns_nxt;
         ew_q    <= ew_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      ticks_nxt = ticks_q;
      walk_nxt  = walk_q;
      pend_nxt  = pend_q;
      req_eff   = pend_q | ped_req;
      is_green  = (state_q == NS_G) || (state_q == EW_G);
      illegal   = (state_q > EW_Y);

      // Requests latch even while frozen; the WALK interval itself ignores them.
      if (ped_req && !walk_q)
         pend_nxt = 1'b1;

      if (enable) begin
         if (ticks_q == 32'd0) begin
            case (state_q)
               RED_NS: begin
                  state_nxt = NS_G;
                  ticks_nxt = D_GREEN;
                  walk_nxt  = 1'b0;
               end
               NS_G: begin
                  state_nxt = NS_Y;
                  ticks_nxt = D_YELLOW;
               end
               NS_Y: begin
                  state_nxt = RED_EW;
                  ticks_nxt = req_eff ? D_WALK : D_ALL_RED;
                  walk_nxt  = req_eff;
                  if (req_eff)
                     pend_nxt = 1'b0;
               end
               RED_EW: begin
                  state_nxt = EW_G;
                  ticks_nxt = D_GREEN;
                  walk_nxt  = 1'b0;
               end
               EW_G: begin
                  state_nxt = EW_Y;
                  ticks_nxt = D_YELLOW;
               end
               EW_Y: begin
                  state_nxt = RED_NS;
                  ticks_nxt = req_eff ? D_WALK : D_ALL_RED;
                  walk_nxt  = req_eff;
                  if (req_eff)
                     pend_nxt = 1'b0;
               end
               default: begin
                  state_nxt = RED_NS;
                  ticks_nxt = D_ALL_RED;
                  walk_nxt  = 1'b0;
               end
            endcase
         end else if (is_green && req_eff && (ticks_q > D_SHORT)) begin
            ticks_nxt = D_SHORT;
         end else begin
            ticks_nxt = ticks_q - 32'd1;
         end
      end

      if (illegal) begin
         state_nxt = RED_NS;
         ticks_nxt = D_ALL_RED;
         walk_nxt  = 1'b0;
      end
   end

   // Lamps are registered from the next state so they switch with phase.
   always_comb begin
      ns_nxt = LAMP_R;
      ew_nxt = LAMP_R;
      case (state_nxt)
         NS_G:    ns_nxt = LAMP_G;
         NS_Y:    ns_nxt = LAMP_Y;
         EW_G:    ew_nxt = LAMP_G;
         EW_Y:    ew_nxt = LAMP_Y;
         default: begin
            ns_nxt = LAMP_R;
            ew_nxt = LAMP_R;
         end
      endcase
   end

   assign ns_light        = ns_q;
   assign ew_light        = ew_q;
   assign ped_walk        = walk_q;
   assign ped_pending     = pend_q;
   assign phase           = state_q;
   assign ticks_remaining = ticks_q;

endmodule
